// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: one bit per cycle shift-add multiply
// and restoring divide on magnitudes, with a final FIX cycle that restores signs.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     ph_q, ph_d, pl_q, pl_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + ONE_2W;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    if (is_signed && x[WIDTH-1]) begin
      return neg_w(x);
    end else begin
      return x;
    end
  endfunction

  // ph holds the running high half (mult) or partial remainder (div); pl holds multiplier / quotient.
  logic               is_div_s, is_mac_s;
  logic [WIDTH:0]     mul_sum_s, div_sh_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] prod_s, mac_s;
  logic [WIDTH-1:0]   quot_s, rem_s, res_hi_s, res_lo_s;

  assign is_div_s   = ~op_q[2] & op_q[1];
  assign is_mac_s   = op_q[2];
  assign mul_sum_s  = {1'b0, ph_q} + (pl_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});
  assign div_sh_s   = {ph_q, pl_q[WIDTH-1]};
  assign div_ge_s   = div_sh_s >= {1'b0, mb_q};
  assign div_diff_s = div_sh_s[WIDTH-1:0] - mb_q;
  assign prod_s     = (sa_q ^ sb_q) ? neg_2w({ph_q, pl_q}) : {ph_q, pl_q};
  assign mac_s      = op_q[1] ? (acc_q - prod_s) : (acc_q + prod_s);
  assign quot_s     = (sa_q ^ sb_q) ? neg_w(pl_q) : pl_q;
  assign rem_s      = sa_q ? neg_w(ph_q) : ph_q;

  // Final HI/LO value selected in the FIX cycle.
  always_comb begin
    res_hi_s = prod_s[2*WIDTH-1:WIDTH];
    res_lo_s = prod_s[WIDTH-1:0];
    if (is_div_s) begin
      if (mb_q == {WIDTH{1'b0}}) begin
        res_hi_s = a_q;
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_hi_s = rem_s;
        res_lo_s = quot_s;
      end
    end else if (is_mac_s) begin
      res_hi_s = mac_s[2*WIDTH-1:WIDTH];
      res_lo_s = mac_s[WIDTH-1:0];
    end else begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // MTHI/MTLO win over start; a coinciding start is dropped.
        if (hi_we || lo_we) begin
          if (hi_we) hi_d = a; else hi_d = hi_q;
          if (lo_we) lo_d = a; else lo_d = lo_q;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_ITER;
          cnt_d   = {CW{1'b0}};
          op_d    = op;
          a_d     = a;
          mb_d    = magnitude(b, ~op[0]);
          sa_d    = ~op[0] & a[WIDTH-1];
          sb_d    = ~op[0] & b[WIDTH-1];
          acc_d   = {hi_q, lo_q};
          ph_d    = {WIDTH{1'b0}};
          pl_d    = magnitude(a, ~op[0]);
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + ONE_C;
        if (is_div_s) begin
          ph_d = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
          pl_d = {pl_q[WIDTH-2:0], div_ge_s};
        end else begin
          ph_d = mul_sum_s[WIDTH:1];
          pl_d = {mul_sum_s[0], pl_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) state_d = S_FIX; else state_d = S_ITER;
      end
      S_FIX: begin
        hi_d    = res_hi_s;
        lo_d    = res_lo_s;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 3'd0;
      a_q     <= {WIDTH{1'b0}};
      mb_q    <= {WIDTH{1'b0}};
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
      ph_q    <= {WIDTH{1'b0}};
      pl_q    <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the pipelined CPU's execute stage, owning the HI/LO register pair. Performs signed/unsigned multiply, divide, and multiply-accumulate/subtract (MADD/MSUB family) using a one-bit-per-cycle shift-add / restoring-divide datapath. Fixed latency is derived from WIDTH. Busy drives the hazard unit's stall of HI/LO-dependent instructions; divide-by-zero and overflow results are fully defined.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation `op` on `a`, `b`; accepted only when idle
- op  in  3  operation select:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
- a  in  WIDTH  operand 1 / dividend; also the write data for hi_we/lo_we
- b  in  WIDTH  operand 2 / divisor
- hi_we  in  1  write `a` into HI (MTHI)
- lo_we  in  1  write `a` into LO (MTLO)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO take a result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Idle priority per cycle:
  - hi_we and lo_we may both apply in the same cycle.
  - If start coincides with any write: the writes apply and start is dropped (no busy, no done).
- Accept: start=1 while busy=0 and no write.
  - Captures op, |a|, |b|, the operand signs, and for op 4-7 the accumulator {HI,LO}.
  - busy rises.
- While busy, start, hi_we and lo_we are ignored; the hazard unit stalls them. HI/LO stay visible and unchanged.
- States:
  - IDLE → ITER on accept.
  - ITER runs WIDTH iterations, one bit per cycle.
  - ITER → FIX after the last iteration.
  - FIX → IDLE after one cycle.
- Signed ops (0, 2, 4, 6) iterate on unsigned magnitudes; FIX restores the signs.
- Multiply: product sign = sign(a) XOR sign(b). The full 2·WIDTH-bit product goes to {HI,LO}.
- MADD/MADDU: {HI,LO} = acc + product. MSUB/MSUBU: {HI,LO} = acc − product. Both wrap modulo 2^(2·WIDTH).
- Divide: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): LO = all ones, HI = a as captured.
- Signed overflow (DIV, a=MIN, b=−1): LO = MIN, HI = 0.
- Reset at any time, including mid-operation:
  - Resets busy=0, done=0, hi=0, lo=0, state IDLE.
  - The in-flight result is discarded.

## Timing
- Reset values: busy 0, done 0, hi 0, lo 0.
- Let the accepting edge be T0.
  - busy = 1 from after T0 until the edge T0+WIDTH+1, where it returns to 0.
  - busy is high for exactly WIDTH+1 cycles, identical for every op.
- At edge T0+WIDTH+1:
  - hi/lo load the result.
  - done = 1 for one cycle.
  - busy = 0 in that same cycle.
- Back-to-back: start may be asserted in the cycle done=1; it is accepted at that edge.
- MADD/MSUB use the HI/LO value at T0. Writes issued after T0 are ignored because busy=1.
- hi_we/lo_we in an idle cycle update hi/lo at the next edge; busy and done are unaffected.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=7 → busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle.
- DIVU a=100, b=7 → lo=14, hi=2. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- hi_we=lo_we=1, a=1 → hi=lo=1. Then MSUBU a=2, b=1 → {hi,lo} = 0x00000000_FFFFFFFF.
- Start MULTU at T0; start again at T0+5 with hi_we → both ignored. Reset at T0+10 → busy=0, hi=lo=0, no done.
- WIDTH=8 build: MULTU a=0xFF, b=0xFF → busy 9 cycles; hi=0xFE, lo=0x01.
